// File: rtl/context_swapper.sv
// context_swapper: moves one register context between the program half of the
// register bank and data memory, one word per cycle, in either direction.
module context_swapper #(
    parameter int unsigned NREGS     = 32,
    parameter logic        PROG_BANK = 1'b1
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic                     Save,
    input  logic [31:0]              ProcBase,
    input  logic [31:0]              RegData,
    input  logic [31:0]              MemDataIn,
    output logic [$clog2(NREGS)-1:0] RegAddr,
    output logic                     RegSelect,
    output logic                     RegWrite,
    output logic [31:0]              RegDataOut,
    output logic [31:0]              MemAddr,
    output logic                     MemRead,
    output logic                     MemWrite,
    output logic [31:0]              MemDataOut,
    output logic                     Busy,
    output logic                     Done
);
    localparam int unsigned   IW   = $clog2(NREGS);
    localparam logic [IW-1:0] LAST = IW'(NREGS - 1);

    typedef enum logic [2:0] {IDLE, SAVE, RESTORE, FLUSH, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   base_q, base_d;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Base only matters outside IDLE, where every output using it is gated.
    always_ff @(posedge Clock) begin
        base_q <= base_d;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        base_d     = base_q;
        RegAddr    = '0;
        RegSelect  = 1'b0;
        RegWrite   = 1'b0;
        RegDataOut = '0;
        MemAddr    = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemDataOut = '0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    base_d  = ProcBase;
                    idx_d   = '0;
                    state_d = Save ? SAVE : RESTORE;
                end
            end
            SAVE: begin
                Busy       = 1'b1;
                RegSelect  = PROG_BANK;
                RegAddr    = idx_q;
                MemAddr    = base_q + 32'(idx_q);
                MemDataOut = RegData;
                MemWrite   = 1'b1;
                idx_d      = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            RESTORE: begin
                Busy      = 1'b1;
                RegSelect = PROG_BANK;
                MemRead   = 1'b1;
                MemAddr   = base_q + 32'(idx_q);
                // Memory read data trails its address by a cycle, so writes lag by one index.
                if (idx_q != '0) begin
                    RegWrite   = 1'b1;
                    RegAddr    = idx_q - 1'b1;
                    RegDataOut = MemDataIn;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                Busy       = 1'b1;
                RegSelect  = PROG_BANK;
                RegWrite   = 1'b1;
                RegAddr    = LAST;
                RegDataOut = MemDataIn;
                state_d    = DONE;
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_context_swapper.sv
// Bench for context_swapper: behavioural bank/memory models plus a scoreboard of
// expected transfers compared as the DUT issues them.
module tb_context_swapper;
    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic        Save = 1'b0;
    logic [31:0] ProcBase = '0;
    logic [31:0] RegData;
    logic [31:0] MemDataIn = '0;
    logic [4:0]  RegAddr;
    logic        RegSelect, RegWrite, MemRead, MemWrite, Busy, Done;
    logic [31:0] RegDataOut, MemAddr, MemDataOut;

    logic [31:0] prog_bank [32];
    logic [31:0] os_bank   [32];
    logic [31:0] mem       [4096];
    logic [63:0] exp_q [$];
    int pass_cnt = 0;
    int total_cnt = 0;

    context_swapper dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Save(Save), .ProcBase(ProcBase),
        .RegData(RegData), .MemDataIn(MemDataIn), .RegAddr(RegAddr), .RegSelect(RegSelect),
        .RegWrite(RegWrite), .RegDataOut(RegDataOut), .MemAddr(MemAddr), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemDataOut(MemDataOut), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    assign RegData = RegSelect ? prog_bank[RegAddr] : os_bank[RegAddr];

    always @(posedge Clock) begin
        if (RegWrite) begin
            if (RegSelect) prog_bank[RegAddr] <= RegDataOut;
            else           os_bank[RegAddr]   <= RegDataOut;
        end
        if (MemWrite) mem[MemAddr[11:0]] <= MemDataOut;
        if (MemRead)  MemDataIn <= mem[MemAddr[11:0]];
    end

    // Called just after a rising edge with the DUT idle; returns in cycle 1 after acceptance.
    task automatic kick(input logic sv, input logic [31:0] base);
        Start = 1'b1; Save = sv; ProcBase = base;
        @(posedge Clock); #1;
        Start = 1'b0; Save = ~sv; ProcBase = ~base;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Start = 1'b1; Save = 1'b1; ProcBase = 32'h1234;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        total_cnt++;
        if ({Busy, Done, RegWrite, MemRead, MemWrite, RegSelect} !== 6'b0)
            $display("FAIL reset_strobes got %b want 000000", {Busy, Done, RegWrite, MemRead, MemWrite, RegSelect});
        else pass_cnt++;
        total_cnt++;
        if ({RegAddr, RegDataOut, MemAddr, MemDataOut} !== 101'b0)
            $display("FAIL reset_data got %h/%h/%h/%h want zeros", RegAddr, RegDataOut, MemAddr, MemDataOut);
        else pass_cnt++;
        Start = 1'b0; Reset = 1'b1;
        repeat (2) @(negedge Clock);
        total_cnt++;
        if (Busy !== 1'b0) $display("FAIL reset_idle busy got %b want 0", Busy);
        else pass_cnt++;
        @(posedge Clock); #1;
    endtask

    task automatic test_save();
        int writes = 0, dones = 0, done_cyc = -1, busy_cnt = 0, sel_bad = 0, excl_bad = 0, mem_bad = 0;
        logic [63:0] e;
        for (int k = 0; k < 32; k++) begin
            prog_bank[k] = 32'hA000_0000 + 32'(k);
            os_bank[k]   = 32'h0500_0000 + 32'(k);
            exp_q.push_back({32'h100 + 32'(k), 32'hA000_0000 + 32'(k)});
        end
        kick(1'b1, 32'h100);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge Clock);
            if (RegSelect !== Busy) sel_bad++;
            if ((MemRead && MemWrite) || (RegWrite && MemWrite)) excl_bad++;
            if (Busy) busy_cnt++;
            if (Done) begin dones++; done_cyc = cyc; end
            if (MemWrite) begin
                writes++;
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL save_write extra write addr %h", MemAddr);
                else begin
                    e = exp_q.pop_front();
                    if ({MemAddr, MemDataOut} !== e)
                        $display("FAIL save_write got %h:%h want %h:%h", MemAddr, MemDataOut, e[63:32], e[31:0]);
                    else pass_cnt++;
                end
            end
        end
        for (int k = 0; k < 32; k++)
            if (mem[12'h100 + 12'(k)] !== 32'hA000_0000 + 32'(k)) mem_bad++;
        total_cnt++;
        if (done_cyc !== 33 || dones !== 1) $display("FAIL save_done cycle %0d count %0d want 33/1", done_cyc, dones);
        else pass_cnt++;
        total_cnt++;
        if (writes !== 32 || busy_cnt !== 32) $display("FAIL save_counts writes %0d busy %0d want 32/32", writes, busy_cnt);
        else pass_cnt++;
        total_cnt++;
        if (sel_bad !== 0 || excl_bad !== 0) $display("FAIL save_select sel_bad %0d excl_bad %0d want 0/0", sel_bad, excl_bad);
        else pass_cnt++;
        total_cnt++;
        if (mem_bad !== 0) $display("FAIL save_mem bad words %0d want 0", mem_bad);
        else pass_cnt++;
        exp_q.delete();
        @(posedge Clock); #1;
    endtask

    task automatic test_restore();
        int first_rd = -1, first_wr = -1, dones = 0, done_cyc = -1, busy_cnt = 0;
        int rd_bad = 0, reads = 0, excl_bad = 0, sel_bad = 0, bank_bad = 0, os_bad = 0;
        logic [63:0] e;
        for (int k = 0; k < 32; k++) begin
            mem[12'h200 + 12'(k)] = ~32'(k);
            prog_bank[k] = 32'h5555_0000 + 32'(k);
            os_bank[k]   = 32'h0500_0000 + 32'(k);
            exp_q.push_back({32'(k), ~32'(k)});
        end
        kick(1'b0, 32'h200);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge Clock);
            if (RegSelect !== Busy) sel_bad++;
            if ((MemRead && MemWrite) || (RegWrite && MemWrite)) excl_bad++;
            if (Busy) busy_cnt++;
            if (Done) begin dones++; done_cyc = cyc; end
            if (MemRead) begin
                if (first_rd < 0) first_rd = cyc;
                if (MemAddr !== 32'h200 + 32'(reads)) rd_bad++;
                reads++;
            end
            if (RegWrite) begin
                if (first_wr < 0) first_wr = cyc;
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL restore_write extra write reg %0d", RegAddr);
                else begin
                    e = exp_q.pop_front();
                    if ({27'b0, RegAddr, RegDataOut} !== e)
                        $display("FAIL restore_write got %0d:%h want %0d:%h", RegAddr, RegDataOut, e[63:32], e[31:0]);
                    else pass_cnt++;
                end
            end
        end
        for (int k = 0; k < 32; k++) begin
            if (prog_bank[k] !== ~32'(k)) bank_bad++;
            if (os_bank[k] !== 32'h0500_0000 + 32'(k)) os_bad++;
        end
        total_cnt++;
        if (first_rd !== 1 || first_wr !== 2) $display("FAIL restore_lag first read %0d first write %0d want 1/2", first_rd, first_wr);
        else pass_cnt++;
        total_cnt++;
        if (done_cyc !== 34 || dones !== 1 || busy_cnt !== 33)
            $display("FAIL restore_done cycle %0d count %0d busy %0d want 34/1/33", done_cyc, dones, busy_cnt);
        else pass_cnt++;
        total_cnt++;
        if (reads !== 32 || rd_bad !== 0) $display("FAIL restore_reads count %0d bad %0d want 32/0", reads, rd_bad);
        else pass_cnt++;
        total_cnt++;
        if (bank_bad !== 0 || os_bad !== 0) $display("FAIL restore_bank prog bad %0d os bad %0d want 0/0", bank_bad, os_bad);
        else pass_cnt++;
        total_cnt++;
        if (sel_bad !== 0 || excl_bad !== 0) $display("FAIL restore_select sel_bad %0d excl_bad %0d want 0/0", sel_bad, excl_bad);
        else pass_cnt++;
        exp_q.delete();
        @(posedge Clock); #1;
    endtask

    task automatic test_wrap();
        int writes = 0, mem_bad = 0;
        logic [63:0] e;
        for (int k = 0; k < 32; k++) begin
            prog_bank[k] = 32'h7000_0000 + 32'(k);
            exp_q.push_back({32'hFFFF_FFF0 + 32'(k), 32'h7000_0000 + 32'(k)});
        end
        kick(1'b1, 32'hFFFF_FFF0);
        for (int cyc = 1; cyc <= 36; cyc++) begin
            @(negedge Clock);
            if (MemWrite) begin
                writes++;
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL wrap_write extra write addr %h", MemAddr);
                else begin
                    e = exp_q.pop_front();
                    if ({MemAddr, MemDataOut} !== e)
                        $display("FAIL wrap_write got %h:%h want %h:%h", MemAddr, MemDataOut, e[63:32], e[31:0]);
                    else pass_cnt++;
                end
            end
        end
        for (int k = 0; k < 16; k++) begin
            if (mem[12'hFF0 + 12'(k)] !== 32'h7000_0000 + 32'(k)) mem_bad++;
            if (mem[12'(k)] !== 32'h7000_0010 + 32'(k)) mem_bad++;
        end
        total_cnt++;
        if (writes !== 32 || mem_bad !== 0) $display("FAIL wrap_mem writes %0d bad %0d want 32/0", writes, mem_bad);
        else pass_cnt++;
        exp_q.delete();
        @(posedge Clock); #1;
    endtask

    task automatic test_start_while_busy();
        int writes = 0, reads = 0, dones = 0;
        logic [63:0] e;
        for (int k = 0; k < 32; k++) begin
            prog_bank[k] = 32'h3300_0000 + 32'(k);
            exp_q.push_back({32'h300 + 32'(k), 32'h3300_0000 + 32'(k)});
        end
        kick(1'b1, 32'h300);
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge Clock);
            if (MemRead) reads++;
            if (Done) dones++;
            if (MemWrite) begin
                writes++;
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL busy_write extra write addr %h", MemAddr);
                else begin
                    e = exp_q.pop_front();
                    if ({MemAddr, MemDataOut} !== e)
                        $display("FAIL busy_write got %h:%h want %h:%h", MemAddr, MemDataOut, e[63:32], e[31:0]);
                    else pass_cnt++;
                end
            end
            if (cyc == 10) begin Start = 1'b1; Save = 1'b0; ProcBase = 32'h900; end
            if (cyc == 11) Start = 1'b0;
        end
        total_cnt++;
        if (writes !== 32 || reads !== 0 || dones !== 1)
            $display("FAIL busy_ignore writes %0d reads %0d dones %0d want 32/0/1", writes, reads, dones);
        else pass_cnt++;
        exp_q.delete();
        @(posedge Clock); #1;
    endtask

    task automatic test_reset_mid_restore();
        int activity = 0, bank_bad = 0;
        logic [63:0] e;
        for (int k = 0; k < 32; k++) begin
            mem[12'h400 + 12'(k)] = 32'hBEEF_0000 + 32'(k);
            prog_bank[k] = 32'h1111_0000 + 32'(k);
        end
        for (int k = 0; k < 14; k++) exp_q.push_back({32'(k), 32'hBEEF_0000 + 32'(k)});
        kick(1'b0, 32'h400);
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge Clock);
            if (RegWrite) begin
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL abort_write extra write reg %0d", RegAddr);
                else begin
                    e = exp_q.pop_front();
                    if ({27'b0, RegAddr, RegDataOut} !== e)
                        $display("FAIL abort_write got %0d:%h want %0d:%h", RegAddr, RegDataOut, e[63:32], e[31:0]);
                    else pass_cnt++;
                end
            end
        end
        Reset = 1'b0;
        @(negedge Clock);
        total_cnt++;
        if ({Busy, Done, RegWrite, MemRead, MemWrite, RegSelect} !== 6'b0)
            $display("FAIL abort_idle got %b want 000000", {Busy, Done, RegWrite, MemRead, MemWrite, RegSelect});
        else pass_cnt++;
        Reset = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge Clock);
            if (Busy || Done || RegWrite || MemRead || MemWrite) activity++;
        end
        for (int k = 0; k < 32; k++) begin
            if (k < 14 && prog_bank[k] !== 32'hBEEF_0000 + 32'(k)) bank_bad++;
            if (k >= 14 && prog_bank[k] !== 32'h1111_0000 + 32'(k)) bank_bad++;
        end
        total_cnt++;
        if (activity !== 0 || exp_q.size() !== 0)
            $display("FAIL abort_quiet activity %0d pending %0d want 0/0", activity, exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if (bank_bad !== 0) $display("FAIL abort_bank bad regs %0d want 0", bank_bad);
        else pass_cnt++;
        exp_q.delete();
        @(posedge Clock); #1;
    endtask

    task automatic test_back_to_back();
        int dones = 0, first_done = -1, last_done = -1, first_mw = -1, writes = 0, mem_bad = 0;
        logic [63:0] e;
        for (int k = 0; k < 32; k++) begin
            mem[12'h500 + 12'(k)] = 32'hC0DE_0000 ^ 32'(k);
            prog_bank[k] = '0;
        end
        kick(1'b0, 32'h500);
        for (int cyc = 1; cyc <= 75; cyc++) begin
            @(negedge Clock);
            if (Done) begin
                dones++;
                if (first_done < 0) first_done = cyc;
                last_done = cyc;
            end
            if (MemWrite) begin
                if (first_mw < 0) first_mw = cyc;
                writes++;
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL b2b_write extra write addr %h", MemAddr);
                else begin
                    e = exp_q.pop_front();
                    if ({MemAddr, MemDataOut} !== e)
                        $display("FAIL b2b_write got %h:%h want %h:%h", MemAddr, MemDataOut, e[63:32], e[31:0]);
                    else pass_cnt++;
                end
            end
            if (cyc == 35) begin
                Start = 1'b1; Save = 1'b1; ProcBase = 32'h600;
                for (int k = 0; k < 32; k++) exp_q.push_back({32'h600 + 32'(k), 32'hC0DE_0000 ^ 32'(k)});
            end
            if (cyc == 36) begin Start = 1'b0; Save = 1'b0; ProcBase = '0; end
        end
        for (int k = 0; k < 32; k++)
            if (mem[12'h600 + 12'(k)] !== (32'hC0DE_0000 ^ 32'(k))) mem_bad++;
        total_cnt++;
        if (dones !== 2 || first_done !== 34 || last_done !== 68 || first_mw !== 36)
            $display("FAIL b2b_timing dones %0d at %0d,%0d first write %0d want 2 at 34,68 first 36",
                     dones, first_done, last_done, first_mw);
        else pass_cnt++;
        total_cnt++;
        if (writes !== 32 || mem_bad !== 0) $display("FAIL b2b_mem writes %0d bad %0d want 32/0", writes, mem_bad);
        else pass_cnt++;
        exp_q.delete();
        @(posedge Clock); #1;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin prog_bank[k] = '0; os_bank[k] = '0; end
        for (int a = 0; a < 4096; a++) mem[a] = '0;
        test_reset();
        test_save();
        test_restore();
        test_wrap();
        test_start_while_busy();
        test_reset_mid_restore();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/context_swapper.md
# context_swapper

Sequential engine that moves one 32-entry register context between the register bank and data memory: in save mode it reads the program-side bank and writes each word to memory; in restore mode it reads memory and writes each word back into the program-side bank. It is the reader/drainer counterpart of the register bank's write path. The OS issues a save or restore around a process switch, and the core stalls while Busy is high.

## Interface
Parameters:
- NREGS, 32, registers per context; the index counter is 5 bits for 32.
- PROG_BANK, 1'b1, value driven on RegSelect; selects the program half of the bank.

Ports:
- Clock  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-low reset; sampled on the Clock rising edge.
- Start  in  1  one-cycle request; sampled only in IDLE.
- Save  in  1  mode, latched with Start; 1 = save (bank→memory), 0 = restore (memory→bank).
- ProcBase  in  32  context base word address, latched with Start.
- RegData  in  32  combinational read data from the bank at RegAddr.
- MemDataIn  in  32  synchronous memory read data, valid one cycle after MemRead/MemAddr.
- RegAddr  out  5  bank address: the read address in save, the write address in restore.
- RegSelect  out  1  PROG_BANK while Busy, 0 otherwise.
- RegWrite  out  1  bank write strobe.
- RegDataOut  out  32  data for the bank write.
- MemAddr  out  32  memory word address.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- MemDataOut  out  32  data for the memory write.
- Busy  out  1  high from the cycle after an accepted Start until Done.
- Done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SAVE, RESTORE, FLUSH, DONE.
- IDLE:
  - Start=1 latches Save and ProcBase, clears index i to 0.
  - Goes to SAVE if Save=1, else RESTORE.
- SAVE:
  - RegAddr=i, MemAddr=ProcBase+i, MemDataOut=RegData, MemWrite=1.
  - i increments each cycle; at i=NREGS-1 goes to DONE.
- RESTORE:
  - MemRead=1, MemAddr=ProcBase+i.
  - From the second RESTORE cycle on, RegWrite=1, RegAddr=i-1, RegDataOut=MemDataIn.
  - At i=NREGS-1 goes to FLUSH.
- FLUSH: RegWrite=1, RegAddr=NREGS-1, RegDataOut=MemDataIn; goes to DONE.
- DONE: Done=1 for one cycle, Busy=0; returns to IDLE.
- Address arithmetic: ProcBase+i is a 32-bit unsigned add, wrapping modulo 2^32. The 5-bit i is zero-extended.
- Start outside IDLE is ignored; it is not queued.
- Save and ProcBase changes after acceptance have no effect.
- Strobe defaults: all strobes are 0 in IDLE and DONE. MemRead and MemWrite are never high together. RegWrite and MemWrite are never high together.
- Reset (Reset=0 at an edge):
  - State returns to IDLE, i=0, all strobes, Busy and Done go to 0, RegSelect=0.
  - Data and address outputs go to 0.
  - Reset applied mid-operation aborts the transfer; partial writes already made stay in place.

## Timing
- Start is sampled at edge E0.
- Save mode:
  - MemWrite is high during the 32 cycles after E0, i=0..31.
  - Done is high in the 33rd cycle after E0.
  - Latency from Start to Done is 33 cycles.
- Restore mode:
  - MemRead is high for cycles 1..32 after E0.
  - RegWrite is high for cycles 2..33, with RegAddr 0..31.
  - Done is high in cycle 34.
- Busy is high in cycles 1..32 (save) or 1..33 (restore).
- Start is accepted again in the cycle after Done.

## Test plan
- **Save:** preload program bank reg k = 0xA000_0000+k, ProcBase=0x100, Start+Save=1.
  - mem[0x100+k] = 0xA000_0000+k for k=0..31.
  - Done is high exactly 33 cycles after Start.
  - RegSelect=1 throughout Busy.
- **Restore:** mem[0x200+k] = ~k, Start with Save=0.
  - Bank regs 0..31 (program half) hold ~k.
  - The first RegWrite is one cycle after the first MemRead.
  - Done at cycle 34.
  - The OS half is unchanged.
- **Wrap-around:** ProcBase=0xFFFF_FFF0, save.
  - Words 0..15 land at 0xFFFF_FFF0..0xFFFF_FFFF.
  - Words 16..31 land at 0x0..0xF.
- **Start while busy:** a second Start at cycle 10 of a save is ignored.
  - Exactly 32 MemWrites occur.
  - One Done pulse occurs.
- **Reset mid-restore:** Reset=0 at cycle 15.
  - Next cycle: IDLE, all strobes 0, Busy=0, no Done.
  - Bank regs 0..13 are updated; regs 14..31 keep their old values.
- **Back-to-back:** Start a save in the cycle after Done of a restore.
  - The save is accepted.
  - Memory contents equal the just-restored values.
